// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and types for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int ADDR_W          = 32;
  localparam int INSTR_W         = 32;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int DBG_CNT_W       = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    fetch_state_e           state;
    logic [DBG_CNT_W-1:0]   drop_cnt;
    logic [DBG_CNT_W-1:0]   outstanding;
    logic [DBG_CNT_W-1:0]   fifo_count;
  } fetch_dbg_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
interface if_fetch_if;
  import if_fetch_pkg::*;

  // A request transfers on a cycle with req && gnt; an ungranted req may drop or change addr.
  // Each transfer returns exactly one rvalid beat later, in request order, with no backpressure.
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_fetch_fifo.sv
// Small circular FIFO with synchronous clear, combinational head and legal push+pop when full.
module if_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, empty, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: credit-limited imem requests, prefetch FIFO, stall handling and redirect flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                FIFO_DEPTH  = 2,
  parameter int                INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               i_redirect_en,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  if_fetch_if.master         imem,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output fetch_dbg_t         o_dbg
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int ENT_W = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  ofifo_count, pcq_count;
  logic [ENT_W-1:0]  ofifo_head;
  logic [ADDR_W-1:0] pcq_head;
  logic [CNT_W:0]    in_use;
  logic              rsp_live, rsp_drop, rsp_keep, grant, pop;

  // Responses with nothing outstanding are leftovers from before a reset and are ignored.
  assign rsp_live = imem.rvalid && (outstanding_q != '0);
  assign rsp_drop = rsp_live && (i_redirect_en || (drop_cnt_q != '0));
  assign rsp_keep = rsp_live && !rsp_drop;

  assign o_valid = (ofifo_count != '0);
  assign pop     = o_valid && !stall && !i_redirect_en;

  // An entry popped this cycle frees its slot at the same edge, so it returns credit immediately.
  assign in_use   = {1'b0, outstanding_q} + {1'b0, ofifo_count} - {{CNT_W{1'b0}}, pop};
  assign imem.req  = (state_q != S_BOOT) && !i_redirect_en && (in_use < (CNT_W+1)'(FIFO_DEPTH));
  assign imem.addr = fetch_pc_q;
  assign grant     = imem.req && imem.gnt;

  assign o_pc    = o_valid ? ofifo_head[ENT_W-1:INSTR_W] : '0;
  assign o_instr = o_valid ? ofifo_head[INSTR_W-1:0] : NOP_INSTR;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_live);
    if (i_redirect_en) begin
      fetch_pc_d = i_redirect_pc;
      drop_cnt_d = outstanding_q - CNT_W'(rsp_live);
      state_d    = (drop_cnt_d != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (grant)    fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_FLUSH: if (drop_cnt_d == '0) state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_out_fifo (
    .clk         (clk),
    .rst         (reset),
    .clear_i     (i_redirect_en),
    .push_i      (rsp_keep),
    .push_data_i ({pcq_head, imem.rdata}),
    .pop_i       (pop),
    .head_o      (ofifo_head),
    .count_o     (ofifo_count)
  );

  // PC of each live request, matched to its in-order response.
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W)) u_pc_queue (
    .clk         (clk),
    .rst         (reset),
    .clear_i     (i_redirect_en),
    .push_i      (grant),
    .push_data_i (fetch_pc_q),
    .pop_i       (rsp_keep),
    .head_o      (pcq_head),
    .count_o     (pcq_count)
  );

  assign o_dbg.state       = state_q;
  assign o_dbg.drop_cnt    = DBG_CNT_W'(drop_cnt_q);
  assign o_dbg.outstanding = DBG_CNT_W'(outstanding_q);
  assign o_dbg.fifo_count  = DBG_CNT_W'(ofifo_count);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(rsp_keep && (ofifo_count == CNT_W'(FIFO_DEPTH)) && !pop));
  a_pc_tracked: assert property (@(posedge clk) disable iff (reset)
    rsp_keep |-> (pcq_count != '0));

endmodule
